// File: rtl/sdc_arb_pkg.sv
// Shared types and defaults for the SD-card block-interface arbiter.
package sdc_arb_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, XFER, RELEASE} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 4096;
  localparam int TCNT_W      = 13;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set bit after 'last', wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] pos;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N; k >= 1; k--) begin
      pos = IW'((int'(last) + k) % N);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/sdc_arbiter.sv
// Round-robin owner of the single SD-card block interface shared by IWM drives and SCSI targets.
module sdc_arbiter
  import sdc_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     _systemReset,
  input  logic [NREQ-1:0]          req_rd,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*32-1:0]       req_lba,
  input  logic [NREQ*8-1:0]        req_dout,
  output logic [NREQ-1:0]          req_ack,
  output logic [NREQ-1:0]          sdc_rd,
  output logic [NREQ-1:0]          sdc_wr,
  output logic [31:0]              sdc_lba,
  output logic [7:0]               sdc_data_out,
  input  logic                     sdc_busy,
  input  logic                     sdc_done,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     arb_err
);

  localparam int IW = $clog2(NREQ);

  state_t             state_reg;
  op_t                op_reg;
  logic [NREQ-1:0]    pend_rd_reg, pend_wr_reg;
  logic [NREQ-1:0]    clr_rd, clr_wr;
  logic [IW-1:0]      rr_last_reg;
  logic [TCNT_W-1:0]  tcnt_reg;
  logic               busy_q_reg;
  logic [7:0]         data_hold_reg;
  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [NREQ-1:0]    cand;
  logic [NREQ-1:0]    own_oh;
  logic [31:0]        lba_arr  [NREQ];
  logic [7:0]         dout_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
    assign lba_arr[gi]  = req_lba[32*gi +: 32];
    assign dout_arr[gi] = req_dout[8*gi +: 8];
  end

  assign cand   = pend_rd_reg | pend_wr_reg;
  assign own_oh = NREQ'(1) << owner;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req   (cand),
    .last  (rr_last_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // A winner with both ops pending is served as a read; its write stays queued.
  always_comb begin
    clr_rd = '0;
    clr_wr = '0;
    if (state_reg == IDLE && pick_valid) begin
      if (pend_rd_reg[pick_idx]) clr_rd[pick_idx] = 1'b1;
      else                       clr_wr[pick_idx] = 1'b1;
    end
  end

  assign req_ack      = (state_reg == XFER && sdc_busy) ? own_oh : '0;
  assign sdc_data_out = (state_reg == IDLE) ? data_hold_reg : dout_arr[owner];

  always_ff @(posedge clk or negedge _systemReset) begin
    if (!_systemReset) begin
      state_reg     <= IDLE;
      op_reg        <= OP_RD;
      pend_rd_reg   <= '0;
      pend_wr_reg   <= '0;
      rr_last_reg   <= IW'(NREQ - 1);
      tcnt_reg      <= '0;
      busy_q_reg    <= 1'b0;
      data_hold_reg <= '0;
      owner         <= '0;
      sdc_lba       <= '0;
      sdc_rd        <= '0;
      sdc_wr        <= '0;
      arb_err       <= 1'b0;
    end else begin
      // New requests win over a same-cycle grant clear so none are lost.
      pend_rd_reg <= (pend_rd_reg & ~clr_rd) | req_rd;
      pend_wr_reg <= (pend_wr_reg & ~clr_wr) | req_wr;
      busy_q_reg  <= sdc_busy;
      arb_err     <= 1'b0;
      if (state_reg != IDLE) data_hold_reg <= dout_arr[owner];

      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_idx;
            op_reg    <= pend_rd_reg[pick_idx] ? OP_RD : OP_WR;
            sdc_lba   <= lba_arr[pick_idx];
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          tcnt_reg <= '0;
          if (op_reg == OP_RD) sdc_rd <= own_oh;
          else                 sdc_wr <= own_oh;
          state_reg <= ISSUE;
        end
        ISSUE: begin
          if (sdc_busy) begin
            sdc_rd    <= '0;
            sdc_wr    <= '0;
            state_reg <= XFER;
          end else if (tcnt_reg == TCNT_W'(TIMEOUT - 1)) begin
            sdc_rd    <= '0;
            sdc_wr    <= '0;
            arb_err   <= 1'b1;
            state_reg <= RELEASE;
          end else if (tcnt_reg != '1) begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end
        XFER: begin
          if (sdc_done || (busy_q_reg && !sdc_busy)) state_reg <= RELEASE;
        end
        RELEASE: begin
          rr_last_reg <= owner;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_arbiter.sv
// Directed self-checking bench for sdc_arbiter: grants, fairness, timeout and reset.
module tb_sdc_arbiter;
  import sdc_arb_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            _systemReset;
  logic [N-1:0]    req_rd, req_wr;
  logic [N*32-1:0] req_lba;
  logic [N*8-1:0]  req_dout;
  logic [N-1:0]    req_ack, sdc_rd, sdc_wr;
  logic [31:0]     sdc_lba;
  logic [7:0]      sdc_data_out;
  logic            sdc_busy, sdc_done;
  logic [1:0]      owner;
  logic            arb_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdc_arbiter #(.NREQ(N), .TIMEOUT(4096)) dut (
    .clk          (clk),
    ._systemReset (_systemReset),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_lba      (req_lba),
    .req_dout     (req_dout),
    .req_ack      (req_ack),
    .sdc_rd       (sdc_rd),
    .sdc_wr       (sdc_wr),
    .sdc_lba      (sdc_lba),
    .sdc_data_out (sdc_data_out),
    .sdc_busy     (sdc_busy),
    .sdc_done     (sdc_done),
    .owner        (owner),
    .arb_err      (arb_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while ((sdc_rd | sdc_wr) == '0 && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_seen"}, 32'((sdc_rd | sdc_wr) != '0), 32'd1);
  endtask

  // One complete accepted transfer for requester idx; ends back in IDLE.
  task automatic serve(input string tag, input int idx, input bit is_wr);
    logic [31:0] exp_strb;
    exp_strb = is_wr ? (32'd1 << (idx + N)) : (32'd1 << idx);
    wait_strobe(tag);
    chk({tag, "_strobe"}, 32'({sdc_wr, sdc_rd}), exp_strb);
    chk({tag, "_owner"}, 32'(owner), 32'(idx));
    sdc_busy = 1'b1;
    tick;
    chk({tag, "_ack"}, 32'(req_ack), 32'd1 << idx);
    sdc_done = 1'b1;
    tick;
    sdc_done = 1'b0;
    sdc_busy = 1'b0;
    tick;
    $display("xfer %s owner=%0d op=%s", tag, idx, is_wr ? "wr" : "rd");
  endtask

  initial begin
    _systemReset = 1'b0;
    req_rd = '0; req_wr = '0; req_lba = '0; req_dout = '0;
    sdc_busy = 1'b0; sdc_done = 1'b0;
    #12;
    chk("rst_strobes", 32'({sdc_wr, sdc_rd}), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_lba", sdc_lba, 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_err", 32'(arb_err), 32'd0);
    chk("rst_rrlast", 32'(dut.rr_last_reg), 32'd3);
    @(posedge clk); #1;
    _systemReset = 1'b1;
    tick;

    // Fairness from reset: all four at once -> 0,1,2,3.
    req_rd = 4'b1111; tick; req_rd = '0;
    serve("fair_a0", 0, 1'b0);
    serve("fair_a1", 1, 1'b0);
    serve("fair_a2", 2, 1'b0);
    serve("fair_a3", 3, 1'b0);

    // Leave rr_last at 1, then all four again -> 2,3,0,1.
    req_rd = 4'b0010; tick; req_rd = '0;
    serve("fair_pre1", 1, 1'b0);
    req_rd = 4'b1111; tick; req_rd = '0;
    serve("fair_b2", 2, 1'b0);
    serve("fair_b3", 3, 1'b0);
    serve("fair_b0", 0, 1'b0);
    serve("fair_b1", 1, 1'b0);

    // Single read with LBA one cycle ahead of the strobe.
    req_lba[64 +: 32] = 32'h0000_1234;
    req_dout[16 +: 8] = 8'hA5;
    req_rd = 4'b0100; tick; req_rd = '0;
    tick;
    chk("rd_setup_lba", sdc_lba, 32'h1234);
    chk("rd_setup_strobe", 32'(sdc_rd), 32'd0);
    tick;
    chk("rd_issue_strobe", 32'(sdc_rd), 32'b0100);
    chk("rd_issue_lba", sdc_lba, 32'h1234);
    sdc_busy = 1'b1; tick;
    chk("rd_xfer_ack", 32'(req_ack), 32'b0100);
    chk("rd_xfer_strobe", 32'(sdc_rd), 32'd0);
    chk("rd_xfer_data", 32'(sdc_data_out), 32'hA5);
    sdc_done = 1'b1; tick;
    sdc_done = 1'b0; sdc_busy = 1'b0; tick;
    chk("rd_owner", 32'(owner), 32'd2);
    chk("rd_idle", 32'(dut.state_reg), 32'(IDLE));
    $display("xfer single_rd owner=2 op=rd");

    // Same requester rd+wr: read first, write after the read's release.
    req_rd = 4'b0001; req_wr = 4'b0001; tick; req_rd = '0; req_wr = '0;
    serve("rdwr_rd", 0, 1'b0);
    chk("rdwr_wr_pending", 32'(dut.pend_wr_reg), 32'b0001);
    serve("rdwr_wr", 0, 1'b1);

    // Capture while owner 0 is in XFER.
    req_rd = 4'b0001; tick; req_rd = '0;
    wait_strobe("cap");
    sdc_busy = 1'b1; tick;
    req_rd = 4'b0010; tick; req_rd = '0;
    chk("cap_ack_owner0", 32'(req_ack), 32'b0001);
    chk("cap_pending", 32'(dut.pend_rd_reg), 32'b0010);
    sdc_done = 1'b1; tick;
    sdc_done = 1'b0; sdc_busy = 1'b0; tick;
    $display("xfer cap owner=0 op=rd");
    serve("cap_next", 1, 1'b0);

    // Timeout on a write the host never accepts.
    req_wr = 4'b1000; tick; req_wr = '0;
    wait_strobe("tmo");
    chk("tmo_strobe", 32'(sdc_wr), 32'b1000);
    begin
      int n = 0;
      while (!arb_err && n < 5000) begin
        tick;
        n++;
      end
      chk("tmo_cycles", 32'(n), 32'd4096);
    end
    chk("tmo_strobe_drop", 32'({sdc_wr, sdc_rd}), 32'd0);
    tick;
    chk("tmo_err_once", 32'(arb_err), 32'd0);
    chk("tmo_idle", 32'(dut.state_reg), 32'(IDLE));
    chk("tmo_pend_wr", 32'(dut.pend_wr_reg), 32'd0);
    $display("xfer timeout owner=3 op=wr");

    // Asynchronous reset in the middle of XFER.
    req_rd = 4'b0100; tick; req_rd = '0;
    wait_strobe("rst_mid");
    sdc_busy = 1'b1; req_wr = 4'b0010; tick; req_wr = '0;
    chk("rstm_ack_before", 32'(req_ack), 32'b0100);
    #2 _systemReset = 1'b0;
    #1;
    chk("rstm_ack", 32'(req_ack), 32'd0);
    chk("rstm_strobes", 32'({sdc_wr, sdc_rd}), 32'd0);
    chk("rstm_pend", 32'({dut.pend_wr_reg, dut.pend_rd_reg}), 32'd0);
    chk("rstm_rrlast", 32'(dut.rr_last_reg), 32'd3);
    chk("rstm_idle", 32'(dut.state_reg), 32'(IDLE));
    sdc_busy = 1'b0;
    @(posedge clk); #1;
    _systemReset = 1'b1;
    tick;
    $display("xfer reset_mid owner=2 op=rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
